bldc_hall_decoder: RTL and testbench
====================================

// Module: bldc_hall_decoder
// PURPOSE
//  Receive-side counterpart of the bldc driver. Reads the motor's three hall
//  sensors and decodes them into commutation sector, signed step position,
//  direction and step period. Position drives the driver's feedback input;
//  period is the speed estimate.
//  Sits between the hall input pins and the bldc feedback/velocity loop.
// PARAMETERS
//  FILTER_LEN   16        clk cycles a synced hall code must be stable to accept
//  PERIOD_BITS  24        width of step-period counter/output
//  INVERT       0         1: invert all three hall inputs after sync
// PORTS
//  clk       in   1            system clock
//  rst       in   1            asynchronous, active-high reset
//  hall_u    in   1            hall sensor U (asynchronous pin)
//  hall_v    in   1            hall sensor V (asynchronous pin)
//  hall_w    in   1            hall sensor W (asynchronous pin)
//  clear     in   1            sync: zero position, clear sticky errors
//  sector    out  3            current sector 0..5
//  position  out  32 signed    accumulated steps, +1 fwd / -1 rev
//  direction out  1            1 = last step forward, 0 = reverse
//  period    out  PERIOD_BITS  clk cycles between last two same-dir steps
//  valid     out  1            sector/position trustworthy
//  err_inv   out  1            sticky: invalid code 000/111 accepted
//  err_skip  out  1            sticky: sector jump of 2, 3 or 4
// BEHAVIOUR
//  Reset: all outputs 0; period = all-ones; state INIT; sync/filter regs 0.
//  Sync and filter:
//  - 2-FF synchroniser per input, then optional INVERT. code = {u,v,w}.
//  - Filter holds a candidate and a counter. Counter returns to 0 when the
//    synced code differs from the candidate; candidate then takes the code.
//  - Filtered code updates when counter hits FILTER_LEN-1.
//  - Pin edge to filtered update = FILTER_LEN+2 clk.
//  - Pulses shorter than FILTER_LEN are ignored.
//  Sector map (uvw): 101->0 100->1 110->2 010->3 011->4 001->5; 000/111 invalid.
//  FSM (evaluated on cycle filtered code changes, or in INIT every cycle):
//  - INIT: first valid filtered code -> load sector, valid=1, -> RUN.
//    Invalid code -> err_inv=1, -> FAULT.
//  - RUN, new valid code, d = (new-old) mod 6:
//    d=1: position+1, direction=1.
//    d=5: position-1, direction=0.
//    d=2..4: err_skip=1, position unchanged, sector updated.
//  - RUN, invalid code -> valid=0, err_inv=1, -> FAULT.
//  - FAULT: valid code -> load sector, no position change, valid=1, -> RUN.
//  - Outputs update 1 clk after the filtered change.
//  Period:
//  - cnt increments every clk, saturating at all-ones.
//  - On a +/-1 step in the same direction as the previous step:
//    period <= cnt+1, then cnt <= 0.
//  - On a reversal or skip, or on leaving FAULT: period <= all-ones, cnt <= 0.
//  - If cnt saturates, period <= all-ones (stalled motor).
//  Arithmetic: position wraps two's complement; no saturation.
//  clear:
//  - position <= 0, err_inv <= 0, err_skip <= 0.
//  - A step on the same cycle is discarded; position = 0 wins.
//  - The step's sector, direction and period still update.
//  - Errors re-set on the following cycle if the condition persists.
//  rst mid-operation: immediate return to reset values; next accepted code
//  re-enters via INIT.
// TESTING
//  1. rst, hold 101 -> FILTER_LEN+3 clk later: valid=1, sector=0, position=0.
//  2. Fwd 101,100,110,010,011,001,101, 1000 clk each (FILTER_LEN=16):
//     position=6, direction=1, period=1000.
//  3. Hold 100; pulse 110 for 10 clk -> sector stays 1, position unchanged.
//     Pulse 110 for 20 clk -> sector=2 (step accepted).
//  4. Sector 1, drive 111 -> valid=0, err_inv=1.
//     Then 110 -> valid=1, sector=2, position unchanged, period=all-ones.
//  5. Sector 0 -> 110: err_skip=1, sector=2, position unchanged.
//     Then reverse 110->100: position-1, direction=0, period=all-ones.
//     Hold 2^24 clk -> period stays all-ones.
//  6. clear on the same clk as a fwd step -> position=0, sector advanced,
//     errors 0. rst mid-run -> all outputs 0, period all-ones, valid=0.

Source files
------------

// File: rtl/bldc_hall_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : bldc_hall_decoder
//  Purpose  : Decodes three asynchronous BLDC hall sensor pins into a
//             commutation sector, a signed step count, the direction of the
//             last step and the clk-cycle period between same-direction steps.
//  Ports    : clk, rst (async, active-high)
//             hall_u/v/w  raw hall pins (synchronised internally)
//             clear       zero position and sticky errors
//             sector      current sector 0..5
//             position    signed accumulated steps (+1 fwd, -1 rev, wraps)
//             direction   1 = last step forward
//             period      cycles between the last two same-direction steps,
//                         all-ones when unknown or stalled
//             valid       sector/position trustworthy
//             err_inv     sticky: invalid code 000/111 accepted
//             err_skip    sticky: sector jump of 2..4
//  Revision : 1.0  initial release
// ============================================================================
module bldc_hall_decoder #(
    parameter int FILTER_LEN  = 16,
    parameter int PERIOD_BITS = 24,
    parameter bit INVERT      = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hall_u,
    input  logic                   hall_v,
    input  logic                   hall_w,
    input  logic                   clear,
    output logic [2:0]             sector,
    output logic signed [31:0]     position,
    output logic                   direction,
    output logic [PERIOD_BITS-1:0] period,
    output logic                   valid,
    output logic                   err_inv,
    output logic                   err_skip
);

    localparam int                   CNT_W   = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0]     FLT_PRE = CNT_W'(FILTER_LEN - 2);
    localparam logic [CNT_W-1:0]     FLT_TOP = CNT_W'(FILTER_LEN - 1);
    localparam logic [PERIOD_BITS-1:0] PER_MAX = '1;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser and stability filter
    // ------------------------------------------------------------------
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       code;
    logic [2:0]       cand;
    logic [2:0]       filt;
    logic [CNT_W-1:0] fcnt;
    logic             acc;       // filter accepted a code this cycle
    logic             acc_chg;   // ... and it differs from the previous one

    assign code = sync2 ^ {3{INVERT}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 3'b000;
            sync2   <= 3'b000;
            cand    <= 3'b000;
            filt    <= 3'b000;
            fcnt    <= '0;
            acc     <= 1'b0;
            acc_chg <= 1'b0;
        end else begin
            sync1   <= {hall_u, hall_v, hall_w};
            sync2   <= sync1;
            acc     <= 1'b0;
            acc_chg <= 1'b0;
            if (code != cand) begin
                cand <= code;
                fcnt <= '0;
            end else if (fcnt == FLT_PRE) begin
                // Accept on the same edge the counter reaches its top value
                // so pin-to-filtered latency is FILTER_LEN+2 cycles.
                fcnt    <= FLT_TOP;
                filt    <= cand;
                acc     <= 1'b1;
                acc_chg <= (cand != filt);
            end else if (fcnt != FLT_TOP) begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sector decode and circular difference
    // ------------------------------------------------------------------
    function automatic logic [3:0] map_sector(input logic [2:0] c);
        logic [3:0] r;
        case (c)
            3'b101:  r = 4'b1_000;
            3'b100:  r = 4'b1_001;
            3'b110:  r = 4'b1_010;
            3'b010:  r = 4'b1_011;
            3'b011:  r = 4'b1_100;
            3'b001:  r = 4'b1_101;
            default: r = 4'b0_000;
        endcase
        return r;
    endfunction

    logic [3:0] map_res;
    logic       new_ok;
    logic [2:0] new_sec;
    logic [3:0] dsum;
    logic [2:0] dstep;

    assign map_res = map_sector(filt);
    assign new_ok  = map_res[3];
    assign new_sec = map_res[2:0];
    assign dsum    = {1'b0, new_sec} + 4'd6 - {1'b0, sector};
    assign dstep   = (dsum >= 4'd6) ? 3'(dsum - 4'd6) : dsum[2:0];

    // ------------------------------------------------------------------
    // Decoder FSM
    // ------------------------------------------------------------------
    state_t                   state, state_n;
    logic [2:0]               sector_n;
    logic signed [31:0]       pos_n;
    logic                     dir_n;
    logic [PERIOD_BITS-1:0]   per_n;
    logic                     valid_n;
    logic                     ei_n;
    logic                     es_n;
    logic                     have_dir;   // a +/-1 step occurred since the last history break
    logic                     have_dir_n;
    logic [PERIOD_BITS-1:0]   pcnt;
    logic [PERIOD_BITS-1:0]   pcnt_n;
    logic                     pcnt_sat;
    logic [PERIOD_BITS-1:0]   pcnt_inc;
    logic                     step_fwd;

    assign pcnt_sat = (pcnt == PER_MAX);
    // Saturating cnt+1: doubles as the measured period on a step.
    assign pcnt_inc = pcnt_sat ? pcnt : pcnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_INIT;
            sector    <= 3'd0;
            position  <= 32'sd0;
            direction <= 1'b0;
            period    <= PER_MAX;
            valid     <= 1'b0;
            err_inv   <= 1'b0;
            err_skip  <= 1'b0;
            have_dir  <= 1'b0;
            pcnt      <= '0;
        end else begin
            state     <= state_n;
            sector    <= sector_n;
            position  <= pos_n;
            direction <= dir_n;
            period    <= per_n;
            valid     <= valid_n;
            err_inv   <= ei_n;
            err_skip  <= es_n;
            have_dir  <= have_dir_n;
            pcnt      <= pcnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        sector_n   = sector;
        pos_n      = position;
        dir_n      = direction;
        per_n      = period;
        valid_n    = valid;
        ei_n       = err_inv;
        es_n       = err_skip;
        have_dir_n = have_dir;
        pcnt_n     = pcnt_inc;
        step_fwd   = 1'b0;

        if (pcnt_sat) begin
            per_n = PER_MAX;    // stalled motor
        end

        case (state)
            ST_INIT: begin
                if (acc) begin
                    if (new_ok) begin
                        sector_n   = new_sec;
                        valid_n    = 1'b1;
                        per_n      = PER_MAX;
                        pcnt_n     = '0;
                        have_dir_n = 1'b0;
                        state_n    = ST_RUN;
                    end else begin
                        ei_n    = 1'b1;
                        state_n = ST_FAULT;
                    end
                end
            end
            ST_RUN: begin
                if (acc && acc_chg) begin
                    if (new_ok) begin
                        sector_n = new_sec;
                        pcnt_n   = '0;
                        if (dstep == 3'd1 || dstep == 3'd5) begin
                            step_fwd   = (dstep == 3'd1);
                            pos_n      = step_fwd ? position + 32'sd1 : position - 32'sd1;
                            dir_n      = step_fwd;
                            per_n      = (have_dir && (direction == step_fwd)) ? pcnt_inc : PER_MAX;
                            have_dir_n = 1'b1;
                        end else begin
                            es_n       = 1'b1;
                            per_n      = PER_MAX;
                            have_dir_n = 1'b0;
                        end
                    end else begin
                        valid_n = 1'b0;
                        ei_n    = 1'b1;
                        state_n = ST_FAULT;
                    end
                end
            end
            ST_FAULT: begin
                if (!new_ok) begin
                    ei_n = 1'b1;    // re-asserts after a clear while still invalid
                end
                if (acc && acc_chg && new_ok) begin
                    sector_n   = new_sec;
                    valid_n    = 1'b1;
                    per_n      = PER_MAX;
                    pcnt_n     = '0;
                    have_dir_n = 1'b0;
                    state_n    = ST_RUN;
                end
            end
            default: begin
                state_n = ST_INIT;
            end
        endcase

        // clear overrides any concurrent step's position and error updates.
        if (clear) begin
            pos_n = 32'sd0;
            ei_n  = 1'b0;
            es_n  = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bldc_hall_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_bldc_hall_decoder
//  Purpose  : Self-checking bench for bldc_hall_decoder: directed scenarios
//             followed by a randomized hall-sequence walk, compared against
//             an event-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bldc_hall_decoder;

    localparam int FL    = 16;
    localparam int PB    = 12;
    localparam int PMAXI = (1 << PB) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          hall_u, hall_v, hall_w;
    logic          clear;
    logic [2:0]    sector;
    logic signed [31:0] position;
    logic          direction;
    logic [PB-1:0] period;
    logic          valid, err_inv, err_skip;

    bldc_hall_decoder #(
        .FILTER_LEN  (FL),
        .PERIOD_BITS (PB),
        .INVERT      (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hall_u    (hall_u),
        .hall_v    (hall_v),
        .hall_w    (hall_w),
        .clear     (clear),
        .sector    (sector),
        .position  (position),
        .direction (direction),
        .period    (period),
        .valid     (valid),
        .err_inv   (err_inv),
        .err_skip  (err_skip)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // ------------------------------------------------------------------
    // Reference model: acts once per accepted hall code, timestamps in cycles
    // ------------------------------------------------------------------
    int         stab [8] = '{-1, 5, 3, 4, 1, 0, 2, -1};
    logic [2:0] ctab [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

    int         m_mode;     // 0 waiting for first code, 1 tracking, 2 fault
    int         m_sector, m_pos, m_dir, m_valid, m_ei, m_es, m_hist, m_per, m_zt;
    logic [2:0] m_filt;
    logic [2:0] cur_pin;

    task automatic m_reset(input int r);
        m_mode = 0; m_sector = 0; m_pos = 0; m_dir = 0; m_valid = 0;
        m_ei = 0; m_es = 0; m_hist = 0; m_per = PMAXI; m_zt = r; m_filt = 3'b000;
    endtask

    task automatic m_event(input logic [2:0] c, input int e, input bit clr);
        int s;
        int d;
        int nd;
        s = stab[c];
        if (!(m_mode != 0 && c == m_filt)) begin
            m_filt = c;
            if (s < 0) begin
                if (m_mode != 2) begin
                    m_valid = 0; m_ei = 1; m_mode = 2;
                end
            end else if (m_mode != 1) begin
                m_sector = s; m_valid = 1; m_mode = 1;
                m_per = PMAXI; m_zt = e; m_hist = 0;
            end else begin
                d = (s - m_sector + 6) % 6;
                m_sector = s;
                if (d == 1 || d == 5) begin
                    nd = (d == 1) ? 1 : 0;
                    if (m_hist == 1 && m_dir == nd)
                        m_per = (e - m_zt < PMAXI) ? (e - m_zt) : PMAXI;
                    else
                        m_per = PMAXI;
                    m_pos  = m_pos + ((nd == 1) ? 1 : -1);
                    m_dir  = nd; m_hist = 1; m_zt = e;
                end else begin
                    m_es = 1; m_hist = 0; m_per = PMAXI; m_zt = e;
                end
            end
        end
        if (clr) begin
            m_pos = 0; m_ei = 0; m_es = 0;
        end
    endtask

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int ep;
        ep = (cyc - m_zt >= PMAXI + 1) ? PMAXI : m_per;
        chk({tag, ".sector"},    sector,    m_sector);
        chk({tag, ".position"},  position,  m_pos);
        chk({tag, ".direction"}, direction, m_dir);
        chk({tag, ".period"},    period,    ep);
        chk({tag, ".valid"},     valid,     m_valid);
        chk({tag, ".err_inv"},   err_inv,   m_ei);
        chk({tag, ".err_skip"},  err_skip,  m_es);
    endtask

    // Drive a hall code for len cycles; optionally pulse clear on the
    // cycle the resulting step reaches the outputs.
    task automatic seg(input logic [2:0] c, input int len, input bit clr);
        int c0;
        c0 = cyc;
        {hall_u, hall_v, hall_w} = c;
        cur_pin = c;
        if (len >= FL) m_event(c, c0 + FL + 3, clr);
        for (int i = 1; i <= len; i++) begin
            @(posedge clk); #1;
            if (clr && i == FL + 2) clear = 1'b1;
            if (clr && i == FL + 3) clear = 1'b0;
        end
    endtask

    task automatic do_reset(input logic [2:0] c);
        rst = 1'b1;
        clear = 1'b0;
        {hall_u, hall_v, hall_w} = c;
        cur_pin = c;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset(cyc);
        m_event(c, cyc + FL + 3, 1'b0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] nxt;
        logic [2:0] g;
        int         r;
        int         len;
        int         s;

        // 1. reset with 101 held: latency FILTER_LEN+3 to valid
        do_reset(3'b101);
        repeat (FL + 2) @(posedge clk);
        #1;
        chk("t1.valid_before", valid, 0);
        @(posedge clk); #1;
        chk("t1.valid_after", valid, 1);
        chk("t1.sector", sector, 0);
        chk("t1.position", position, 0);
        repeat (1000 - FL - 3) @(posedge clk);
        #1;
        check_all("t1");

        // 2. full forward revolution at 1000 clk per step
        for (int i = 1; i <= 6; i++) begin
            seg(ctab[i % 6], 1000, 1'b0);
            check_all("t2");
        end
        chk("t2.pos6", position, 6);
        chk("t2.per1000", period, 1000);
        chk("t2.dir", direction, 1);

        // 3. glitch rejection and the FILTER_LEN boundary
        seg(3'b100, 1000, 1'b0);
        seg(3'b110, 10, 1'b0);
        seg(3'b100, 200, 1'b0);
        check_all("t3.glitch10");
        seg(3'b110, FL - 1, 1'b0);
        seg(3'b100, 200, 1'b0);
        check_all("t3.glitch15");
        seg(3'b110, FL, 1'b0);
        seg(3'b100, 300, 1'b0);
        check_all("t3.pulse16");
        seg(3'b110, 20, 1'b0);
        check_all("t3.pulse20");
        chk("t3.sector2", sector, 2);
        seg(3'b110, 500, 1'b0);

        // 4. invalid code, clear while faulted, recovery
        seg(3'b100, 500, 1'b0);
        seg(3'b111, 500, 1'b0);
        check_all("t4.fault");
        pulse_clear();
        m_pos = 0; m_es = 0;
        chk("t4.clr_ei", err_inv, 0);
        chk("t4.clr_pos", position, 0);
        @(posedge clk); #1;
        chk("t4.ei_reset", err_inv, 1);
        seg(3'b110, 500, 1'b0);
        check_all("t4.recover");
        chk("t4.per_max", period, PMAXI);

        // 5. skip, reversal, stall
        seg(3'b100, 500, 1'b0);
        seg(3'b101, 500, 1'b0);
        pulse_clear();
        m_pos = 0; m_ei = 0; m_es = 0;
        check_all("t5.cleared");
        seg(3'b110, 500, 1'b0);
        check_all("t5.skip");
        chk("t5.es", err_skip, 1);
        seg(3'b100, 500, 1'b0);
        check_all("t5.rev");
        chk("t5.rev_per", period, PMAXI);
        repeat (PMAXI + 100) @(posedge clk);
        #1;
        check_all("t5.stall");
        seg(3'b101, 300, 1'b0);
        check_all("t5.after_stall");
        seg(3'b001, 300, 1'b0);
        check_all("t5.rev_same");

        // 6. clear coincident with a forward step, then async reset
        seg(3'b101, 500, 1'b0);
        seg(3'b100, 500, 1'b1);
        check_all("t6.clr_step");
        chk("t6.pos0", position, 0);
        #4;
        rst = 1'b1;
        #1;
        chk("t6.rst_sector", sector, 0);
        chk("t6.rst_pos", position, 0);
        chk("t6.rst_dir", direction, 0);
        chk("t6.rst_valid", valid, 0);
        chk("t6.rst_per", period, PMAXI);
        chk("t6.rst_errs", {err_inv, err_skip}, 0);
        @(posedge clk); #1;
        do_reset(3'b100);
        repeat (500) @(posedge clk);
        #1;
        check_all("t6.reinit");

        // Randomized walk
        for (int it = 0; it < 50; it++) begin
            r = $urandom_range(0, 99);
            if (m_mode == 2) begin
                nxt = ctab[$urandom_range(0, 5)];
            end else if (r < 75) begin
                s = (m_sector + (($urandom_range(0, 1) == 1) ? 1 : 5)) % 6;
                nxt = ctab[s];
            end else if (r < 87) begin
                s = (m_sector + $urandom_range(2, 4)) % 6;
                nxt = ctab[s];
            end else if (r < 95) begin
                nxt = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'b000;
            end else begin
                nxt = cur_pin;
            end
            if ($urandom_range(0, 99) < 15) begin
                g = 3'($urandom_range(0, 7));
                while (g == cur_pin || g == nxt) g = 3'($urandom_range(0, 7));
                seg(g, $urandom_range(1, FL - 1), 1'b0);
            end
            len = ($urandom_range(0, 99) < 6) ? $urandom_range(PMAXI + 10, PMAXI + 300)
                                              : $urandom_range(FL + 4, 900);
            seg(nxt, len, 1'b0);
            check_all("rnd");
            if ($urandom_range(0, 99) < 8) begin
                pulse_clear();
                @(posedge clk); #1;
                m_pos = 0; m_es = 0;
                m_ei = (m_mode == 2) ? 1 : 0;
                check_all("rnd.clear");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
